// File: rtl/imm_encoder_if.sv
// Handshake bundle for imm_encoder: input beat (immediate, format, base bits) and
// output FIFO head (encoded Inst[31:7], range error), plus the error counter.
interface imm_encoder_if #(
  parameter int CNT_W = 8
);
  // Both sides use valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the producer holds its payload steady until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_imm;
  logic [1:0]       in_type;
  logic [24:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [24:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_imm, in_type, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_imm, in_type, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err, err_cnt
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into Inst[31:7] for I/B/S/J formats, flags unrepresentable
// values, and queues results in a small FIFO. Optional error counter: IMMENC_ERRCNT_EN.
module imm_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [25:0]   mem [FIFO_DEPTH];
  logic          init_done;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [24:0]   enc_inst;
  logic          enc_err;
  logic [25:0]   head;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = bus.out_valid && bus.out_ready;

  // Format packing; bits not owned by the immediate pass through from in_base.
  always_comb begin
    enc_inst = bus.in_base;
    enc_err  = 1'b0;
    case (bus.in_type)
      2'b00: begin
        enc_inst[24:13] = bus.in_imm[11:0];
        enc_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      end
      2'b01: begin
        enc_inst[24]    = bus.in_imm[12];
        enc_inst[23:18] = bus.in_imm[10:5];
        enc_inst[4:1]   = bus.in_imm[4:1];
        enc_inst[0]     = bus.in_imm[11];
        enc_err = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])) || bus.in_imm[0];
      end
      2'b10: begin
        enc_inst[24:18] = bus.in_imm[11:5];
        enc_inst[4:0]   = bus.in_imm[4:0];
        enc_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      end
      2'b11: begin
        enc_inst[24]    = bus.in_imm[20];
        enc_inst[23:14] = bus.in_imm[10:1];
        enc_inst[13]    = bus.in_imm[11];
        enc_inst[12:5]  = bus.in_imm[19:12];
        enc_err = !((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])) || bus.in_imm[0];
      end
      default: begin
        enc_inst = bus.in_base;
        enc_err  = 1'b0;
      end
    endcase
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_inst};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.in_ready  = init_done && !full;
  assign bus.out_valid = !empty;
  assign bus.out_inst  = empty ? 25'd0 : head[24:0];
  assign bus.out_err   = empty ? 1'b0  : head[25];

`ifdef IMMENC_ERRCNT_EN
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (push && enc_err && (err_q != {CNT_W{1'b1}})) begin
      err_q <= err_q + CNT_W'(1);
    end
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table, FIFO corner sequences and random
// traffic scored against an arithmetic reference model.
module tb_imm_encoder;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;

  imm_encoder_if #(.CNT_W(CNT_W)) bus ();

  imm_encoder #(.FIFO_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  logic [25:0] exp_q[$];
  int          exp_cnt = 0;
  bit          have_hold = 0;
  logic [25:0] hold_val;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] imm;
    logic [24:0] base;
    logic [24:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Placement follows the ISA's Inst-bit layout; range is a signed-interval test.
  task automatic ref_encode(input logic [1:0] t, input logic [31:0] imm, input logic [24:0] base,
                            output logic [24:0] inst, output logic err);
    logic [31:0] word;
    int v;
    word = {base, 7'b0};
    v = int'(signed'(imm));
    case (t)
      2'd0: begin
        for (int k = 0; k < 12; k++) word[20+k] = imm[k];
        err = (v < -2048) || (v > 2047);
      end
      2'd2: begin
        for (int k = 0; k < 5; k++)  word[7+k]  = imm[k];
        for (int k = 5; k < 12; k++) word[20+k] = imm[k];
        err = (v < -2048) || (v > 2047);
      end
      2'd1: begin
        word[31] = imm[12];
        for (int k = 5; k < 11; k++) word[20+k] = imm[k];
        for (int k = 1; k < 5; k++)  word[7+k]  = imm[k];
        word[7] = imm[11];
        err = (v < -4096) || (v > 4095) || ((v % 2) != 0);
      end
      default: begin
        word[31] = imm[20];
        for (int k = 1; k < 11; k++)  word[20+k] = imm[k];
        word[20] = imm[11];
        for (int k = 12; k < 20; k++) word[k] = imm[k];
        err = (v < -(1 << 20)) || (v > (1 << 20) - 1) || ((v % 2) != 0);
      end
    endcase
    inst = word[31:7];
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [25:0] head;
    logic [24:0] m_inst;
    logic        m_err;
    if (rst_n) begin
      head = {bus.out_err, bus.out_inst};
      check("out_valid_vs_model", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (have_hold) begin
        check("stall_valid_held", 32'(bus.out_valid), 32'd1);
        check("stall_head_stable", 32'(head), 32'(hold_val));
      end
      have_hold = bus.out_valid && !bus.out_ready;
      hold_val  = head;
      check("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
        check("head_vs_model", 32'(head), 32'(exp_q.pop_front()));
      if (bus.in_valid && bus.in_ready) begin
        ref_encode(bus.in_type, bus.in_imm, bus.in_base, m_inst, m_err);
        exp_q.push_back({m_err, m_inst});
        n_acc++;
`ifdef IMMENC_ERRCNT_EN
        if (m_err && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt   = 0;
    have_hold = 0;
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_beat(input logic [1:0] t, input logic [31:0] imm, input logic [24:0] base);
    bus.in_type = t;
    bus.in_imm  = imm;
    bus.in_base = base;
  endtask

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [31:0] imm, input logic [24:0] base);
    bit acc;
    acc = 0;
    set_beat(t, imm, base);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       return 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
      2:       return 32'($urandom_range(0, 63)) - 32'd32;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [24:0] r_inst;
    logic        r_err;
    int          acc0;

    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 25'h0,       25'h1FFE000, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFF_FFFE, 25'h0,       25'h1FC001F, 1'b0};
    vecs[2] = '{2'd1, 32'h0000_0003, 25'h0,       25'h0000002, 1'b1};
    vecs[3] = '{2'd3, 32'h0000_0800, 25'h000001F, 25'h000201F, 1'b0};
    vecs[4] = '{2'd2, 32'h0000_0800, 25'h0,       25'h1000000, 1'b1};
    vecs[5] = '{2'd0, 32'h0000_07FF, 25'h0001FFF, 25'h0FFFFFF, 1'b0};
    vecs[6] = '{2'd0, 32'h0000_0800, 25'h0,       25'h1000000, 1'b1};
    vecs[7] = '{2'd3, 32'hFFF0_0000, 25'h0,       25'h1000000, 1'b0};
    vecs[8] = '{2'd2, 32'hFFFF_F800, 25'h0,       25'h1000000, 1'b0};
    vecs[9] = '{2'd3, 32'h0000_0001, 25'h0,       25'h0000000, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_beat(2'd0, 32'd0, 25'd0);
    apply_reset();
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_inst",  32'(bus.out_inst),  32'd0);
    check("reset_out_err",   32'(bus.out_err),   32'd0);
    check("reset_err_cnt",   32'(bus.err_cnt),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Table: each beat is visible at the head right after its accepting edge.
    foreach (vecs[i]) begin
      idle(2);
      send(vecs[i].t, vecs[i].imm, vecs[i].base);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_inst", i),  32'(bus.out_inst),  32'(vecs[i].inst));
      check($sformatf("vec%0d_err", i),   32'(bus.out_err),   32'(vecs[i].err));
      @(posedge clk); #1;
    end

    // Back-pressure: fill to depth, hold head, then drain in order.
    idle(3);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_beat(2'd0, 32'd5, 25'h0000A5);
    @(posedge clk); #1;
    set_beat(2'd2, 32'h123, 25'h0F0F0);
    @(posedge clk); #1;
    set_beat(2'd3, 32'h10, 25'h00007);
    ref_encode(2'd0, 32'd5, 25'h0000A5, r_inst, r_err);
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_head_inst", 32'(bus.out_inst), 32'(r_inst));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_pop", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    idle(4);
    check("drained", 32'(exp_q.size()), 32'd0);

    // Streaming: one beat per cycle, no bubbles.
    acc0 = n_acc;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_beat(2'($urandom_range(0, 3)), rand_imm(), 25'($urandom));
      @(negedge clk);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (i > 0) check("stream_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    idle(3);
    check("stream_accepts", 32'(n_acc - acc0), 32'd40);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      set_beat(2'($urandom_range(0, 3)), rand_imm(), 25'($urandom));
      @(posedge clk); #1;
    end
    idle(5);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Mid-operation reset with two entries queued.
    bus.out_ready = 1'b0;
    send(2'd2, 32'h800, 25'd0);
    send(2'd1, 32'h3, 25'd0);
    @(negedge clk);
    check("pre_reset_full", 32'(bus.in_ready), 32'd0);
    #2 apply_reset();
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_inst",  32'(bus.out_inst),  32'd0);
    check("midrst_err_cnt",   32'(bus.err_cnt),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("postrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("postrst_err_cnt",   32'(bus.err_cnt),   32'd0);
    @(posedge clk); #1;

    // 300 out-of-range beats: counter saturates when enabled.
    bus.in_valid = 1'b1;
    set_beat(2'd2, 32'h800, 25'd0);
    repeat (300) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    idle(3);
`ifdef IMMENC_ERRCNT_EN
    check("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);
`else
    check("err_cnt_disabled", 32'(bus.err_cnt), 32'd0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
